// File: rtl/sequenciador_entrada_saida.sv
// IN/OUT sequencer: stalls on IN until a debounced button press captures the
// switches, and latches the datapath value into the display register on OUT.
module sequenciador_entrada_saida #(
   parameter int LARGURA_SWITCH  = 16,
   parameter int LARGURA_DADO    = 32,
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      estagioEntradaUC,
   input  logic                      estagioSaidaUC,
   input  logic                      botaoConfirma,
   input  logic [LARGURA_SWITCH-1:0] switches,
   input  logic [LARGURA_DADO-1:0]   dadoSaidaIn,
   output logic                      estagioEntradaSwitch,
   output logic                      estagioEntradaBanco,
   output logic [LARGURA_DADO-1:0]   dadoEntrada,
   output logic [LARGURA_DADO-1:0]   dadoDisplay,
   output logic                      esperandoEntrada
);

   localparam int LARGURA_CONT = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [2:0] {
      OCIOSO,
      ESPERA_SOLTA,
      ESPERA_PRESSIONA,
      CAPTURA,
      ESCRITA
   } estado_t;

   estado_t estadoReg, estadoNext;

   logic                    sincReg1, sincReg2;
   logic                    botaoSinc;
   logic                    botaoEstavelReg;
   logic [LARGURA_CONT-1:0] contReg;

   logic                    esperandoReg, switchReg, bancoReg;
   logic [LARGURA_DADO-1:0] dadoEntradaReg, dadoDisplayReg;
   logic [LARGURA_DADO-1:0] switchesEstendidos;

   // Raw button is active-low; flops reset to the released level (1).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sincReg1 <= 1'b1;
         sincReg2 <= 1'b1;
      end else begin
         sincReg1 <= botaoConfirma;
         sincReg2 <= sincReg1;
      end
   end

   assign botaoSinc = ~sincReg2;

   // A level change is accepted only after DEBOUNCE_CICLOS consecutive differing samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         botaoEstavelReg <= 1'b0;
         contReg         <= '0;
      end else if (botaoSinc == botaoEstavelReg) begin
         contReg <= '0;
      end else if (contReg == CONT_MAX) begin
         botaoEstavelReg <= botaoSinc;
         contReg         <= '0;
      end else begin
         contReg <= contReg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < LARGURA_DADO; gi++) begin : g_extensao
         if (gi < LARGURA_SWITCH) begin : g_bit
            assign switchesEstendidos[gi] = switches[gi];
         end else begin : g_zero
            assign switchesEstendidos[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estadoReg <= OCIOSO;
      else        estadoReg <= estadoNext;
   end

   // Waiting states abort as soon as the control unit drops the IN stage.
   always_comb begin
      estadoNext = estadoReg;
      case (estadoReg)
         OCIOSO: begin
            if (estagioEntradaUC) estadoNext = ESPERA_SOLTA;
         end
         ESPERA_SOLTA: begin
            if (!estagioEntradaUC)     estadoNext = OCIOSO;
            else if (!botaoEstavelReg) estadoNext = ESPERA_PRESSIONA;
         end
         ESPERA_PRESSIONA: begin
            if (!estagioEntradaUC)    estadoNext = OCIOSO;
            else if (botaoEstavelReg) estadoNext = CAPTURA;
         end
         CAPTURA: estadoNext = ESCRITA;
         ESCRITA: estadoNext = OCIOSO;
         default: estadoNext = OCIOSO;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         esperandoReg   <= 1'b0;
         switchReg      <= 1'b0;
         bancoReg       <= 1'b0;
         dadoEntradaReg <= '0;
         dadoDisplayReg <= '0;
      end else begin
         esperandoReg <= (estadoNext == ESPERA_SOLTA) || (estadoNext == ESPERA_PRESSIONA);
         switchReg    <= (estadoNext == CAPTURA) || (estadoNext == ESCRITA);
         bancoReg     <= (estadoNext == ESCRITA);
         if (estadoNext == CAPTURA) dadoEntradaReg <= switchesEstendidos;
         if (estagioSaidaUC)        dadoDisplayReg <= dadoSaidaIn;
      end
   end

   assign esperandoEntrada     = esperandoReg;
   assign estagioEntradaSwitch = switchReg;
   assign estagioEntradaBanco  = bancoReg;
   assign dadoEntrada          = dadoEntradaReg;
   assign dadoDisplay          = dadoDisplayReg;

endmodule

// File: tb/tb_sequenciador_entrada_saida.sv
// Scoreboard bench: stimulus queues the expected captured word, a monitor pops it on each bank-write pulse.
module tb_sequenciador_entrada_saida;

   logic        clock;
   logic        reset;
   logic        estagioEntradaUC;
   logic        estagioSaidaUC;
   logic        botaoConfirma;
   logic [15:0] switches;
   logic [31:0] dadoSaidaIn;
   logic        estagioEntradaSwitch;
   logic        estagioEntradaBanco;
   logic [31:0] dadoEntrada;
   logic [31:0] dadoDisplay;
   logic        esperandoEntrada;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] fila[$];
   logic prevBanco  = 1'b0;
   logic prevSwitch = 1'b0;

   sequenciador_entrada_saida #(
      .LARGURA_SWITCH (16),
      .LARGURA_DADO   (32),
      .DEBOUNCE_CICLOS(4)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .estagioEntradaUC    (estagioEntradaUC),
      .estagioSaidaUC      (estagioSaidaUC),
      .botaoConfirma       (botaoConfirma),
      .switches            (switches),
      .dadoSaidaIn         (dadoSaidaIn),
      .estagioEntradaSwitch(estagioEntradaSwitch),
      .estagioEntradaBanco (estagioEntradaBanco),
      .dadoEntrada         (dadoEntrada),
      .dadoDisplay         (dadoDisplay),
      .esperandoEntrada    (esperandoEntrada)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nome, got, exp, $time);
      end else begin
         $display("ok   %s: %h (t=%0t)", nome, got, $time);
      end
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Monitor: every bank-write pulse must match a queued expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (reset && estagioEntradaBanco) begin
            chk("banco_um_ciclo", {31'b0, prevBanco}, 32'd0);
            chk("switch_antes_banco", {31'b0, prevSwitch}, 32'd1);
            chk("switch_com_banco", {31'b0, estagioEntradaSwitch}, 32'd1);
            if (fila.size() == 0) begin
               chk("pulso_inesperado", 32'd1, 32'd0);
            end else begin
               chk("sb_dadoEntrada", dadoEntrada, fila.pop_front());
            end
         end
         prevBanco  = estagioEntradaBanco;
         prevSwitch = estagioEntradaSwitch;
      end
   end

   initial begin
      reset = 1'b0; estagioEntradaUC = 1'b0; estagioSaidaUC = 1'b0;
      botaoConfirma = 1'b1; switches = '0; dadoSaidaIn = '0;
      ciclos(2);
      chk("rst_esperando", {31'b0, esperandoEntrada}, 32'd0);
      chk("rst_switch", {31'b0, estagioEntradaSwitch}, 32'd0);
      chk("rst_banco", {31'b0, estagioEntradaBanco}, 32'd0);
      chk("rst_dadoEntrada", dadoEntrada, 32'd0);
      chk("rst_dadoDisplay", dadoDisplay, 32'd0);
      reset = 1'b1;
      ciclos(2);

      // Basic IN with exact latency
      estagioEntradaUC = 1'b1; switches = 16'hA5C3;
      ciclos(3);
      chk("basico_esperando", {31'b0, esperandoEntrada}, 32'd1);
      fila.push_back(32'h0000A5C3);
      botaoConfirma = 1'b0;
      ciclos(6);
      chk("basico_ainda_esperando", {31'b0, esperandoEntrada}, 32'd1);
      chk("basico_sem_captura", {31'b0, estagioEntradaSwitch}, 32'd0);
      ciclos(1);
      chk("basico_switch_c7", {31'b0, estagioEntradaSwitch}, 32'd1);
      chk("basico_esperando_baixo", {31'b0, esperandoEntrada}, 32'd0);
      chk("basico_banco_c7", {31'b0, estagioEntradaBanco}, 32'd0);
      chk("basico_dadoEntrada", dadoEntrada, 32'h0000A5C3);
      ciclos(1);
      chk("basico_banco_c8", {31'b0, estagioEntradaBanco}, 32'd1);
      ciclos(1);
      chk("basico_switch_c9", {31'b0, estagioEntradaSwitch}, 32'd0);
      chk("basico_banco_c9", {31'b0, estagioEntradaBanco}, 32'd0);
      estagioEntradaUC = 1'b0; botaoConfirma = 1'b1;
      ciclos(8);

      // Bounce: 3 low, 1 high, 2 low must be rejected
      estagioEntradaUC = 1'b1; switches = 16'h0F0F;
      ciclos(3);
      botaoConfirma = 1'b0; ciclos(3);
      botaoConfirma = 1'b1; ciclos(1);
      botaoConfirma = 1'b0; ciclos(2);
      botaoConfirma = 1'b1; ciclos(8);
      chk("bounce_esperando", {31'b0, esperandoEntrada}, 32'd1);
      chk("bounce_sem_captura", {31'b0, estagioEntradaSwitch}, 32'd0);
      chk("bounce_dado_mantido", dadoEntrada, 32'h0000A5C3);
      fila.push_back(32'h00000F0F);
      botaoConfirma = 1'b0;
      ciclos(7);
      chk("bounce_limpo_switch", {31'b0, estagioEntradaSwitch}, 32'd1);
      chk("bounce_limpo_dado", dadoEntrada, 32'h00000F0F);
      ciclos(2);
      estagioEntradaUC = 1'b0; botaoConfirma = 1'b1;
      ciclos(8);

      // Held button: press from before the IN is not reused
      botaoConfirma = 1'b0;
      ciclos(8);
      estagioEntradaUC = 1'b1; switches = 16'h1234;
      ciclos(10);
      chk("preso_esperando", {31'b0, esperandoEntrada}, 32'd1);
      chk("preso_sem_captura", {31'b0, estagioEntradaSwitch}, 32'd0);
      botaoConfirma = 1'b1;
      ciclos(8);
      chk("preso_solto_esperando", {31'b0, esperandoEntrada}, 32'd1);
      fila.push_back(32'h00001234);
      botaoConfirma = 1'b0;
      ciclos(7);
      chk("preso_switch", {31'b0, estagioEntradaSwitch}, 32'd1);
      chk("preso_dado", dadoEntrada, 32'h00001234);
      ciclos(3);
      chk("consecutivo_esperando", {31'b0, esperandoEntrada}, 32'd1);
      ciclos(10);
      chk("consecutivo_sem_captura", {31'b0, estagioEntradaSwitch}, 32'd0);
      estagioEntradaUC = 1'b0; botaoConfirma = 1'b1;
      ciclos(8);

      // Abort from ESPERA_PRESSIONA
      estagioEntradaUC = 1'b1; switches = 16'hFFFF;
      ciclos(3);
      chk("abort_esperando", {31'b0, esperandoEntrada}, 32'd1);
      estagioEntradaUC = 1'b0;
      ciclos(1);
      chk("abort_ocioso", {31'b0, esperandoEntrada}, 32'd0);
      botaoConfirma = 1'b0;
      ciclos(8);
      chk("abort_switch", {31'b0, estagioEntradaSwitch}, 32'd0);
      chk("abort_banco", {31'b0, estagioEntradaBanco}, 32'd0);
      chk("abort_dado_mantido", dadoEntrada, 32'h00001234);
      botaoConfirma = 1'b1;
      ciclos(8);

      // OUT register
      estagioSaidaUC = 1'b1; dadoSaidaIn = 32'hDEADBEEF;
      ciclos(1);
      estagioSaidaUC = 1'b0; dadoSaidaIn = 32'h00000001;
      chk("out_display", dadoDisplay, 32'hDEADBEEF);
      ciclos(3);
      chk("out_display_mantido", dadoDisplay, 32'hDEADBEEF);

      // Reset during CAPTURA, then a full IN with concurrent OUT
      estagioEntradaUC = 1'b1; switches = 16'h5555;
      ciclos(3);
      botaoConfirma = 1'b0;
      ciclos(7);
      chk("meio_em_captura", {31'b0, estagioEntradaSwitch}, 32'd1);
      reset = 1'b0;
      #1;
      chk("meio_rst_switch", {31'b0, estagioEntradaSwitch}, 32'd0);
      chk("meio_rst_banco", {31'b0, estagioEntradaBanco}, 32'd0);
      chk("meio_rst_esperando", {31'b0, esperandoEntrada}, 32'd0);
      chk("meio_rst_dadoEntrada", dadoEntrada, 32'd0);
      chk("meio_rst_dadoDisplay", dadoDisplay, 32'd0);
      botaoConfirma = 1'b1;
      ciclos(2);
      reset = 1'b1;
      ciclos(3);
      chk("pos_rst_esperando", {31'b0, esperandoEntrada}, 32'd1);
      switches = 16'hBEEF;
      fila.push_back(32'h0000BEEF);
      botaoConfirma = 1'b0;
      ciclos(6);
      estagioSaidaUC = 1'b1; dadoSaidaIn = 32'hCAFEF00D;
      ciclos(1);
      estagioSaidaUC = 1'b0;
      chk("pos_rst_switch", {31'b0, estagioEntradaSwitch}, 32'd1);
      chk("pos_rst_dado", dadoEntrada, 32'h0000BEEF);
      chk("in_out_display", dadoDisplay, 32'hCAFEF00D);
      ciclos(2);
      estagioEntradaUC = 1'b0; botaoConfirma = 1'b1;
      ciclos(4);

      chk("fila_pendente", fila.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
